// File: rtl/l1_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l1_mem_arbiter_pkg
// Shared types and constants for the L1 memory arbiter slice:
//   arb_state_e     - arbiter FSM states
//   owner_e         - which requester owns the burst in flight
//   RR_DC / RR_IC   - request/grant bit positions in the round-robin arbiter
//   burst_off_bits  - number of low address bits covered by one burst
// ---------------------------------------------------------------------------
package l1_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_BURST,
    ST_WR_BURST
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IC_RD,
    OWN_DC_RD,
    OWN_DC_WB
  } owner_e;

  // Bit positions in the two-requester round-robin arbiter.
  // Pointer value RR_DC means "D-cache read wins a tie".
  localparam int unsigned RR_DC = 0;
  localparam int unsigned RR_IC = 1;

  // Byte-offset width of one burst: log2(len * bytes_per_beat).
  function automatic int unsigned burst_off_bits(input int unsigned len,
                                                 input int unsigned dw);
    return $clog2(len * (dw / 8));
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
// Two-requester round-robin grant with a registered pointer.
//   i_clk, i_rst  : clock, asynchronous active-high reset (pointer -> RR_DC)
//   i_req[1:0]    : request vector (bit RR_DC / RR_IC)
//   i_advance     : grant accepted this cycle; pointer moves to the loser
//   o_gnt[1:0]    : one-hot (or zero) combinational grant
// ---------------------------------------------------------------------------
module mem_rr_arbiter
  import l1_mem_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    o_gnt = '0;
    if (i_req == 2'b11) begin
      o_gnt[r_ptr] = 1'b1;
    end else begin
      o_gnt = i_req;
    end
  end

  // After any accepted grant the pointer favours the other requester.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= 1'(RR_DC);
    end else if (i_advance && (|o_gnt)) begin
      r_ptr <= o_gnt[RR_DC] ? 1'(RR_IC) : 1'(RR_DC);
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// l1_mem_arbiter
// Arbitrates I-cache refills, D-cache refills and D-cache writebacks onto a
// single burst memory port, one burst in flight at a time.
// Ports:
//   cpu_clk, cpu_rst                      clock, async active-high reset
//   ic_rd_req/addr -> ic_rd_valid/data/done   I-cache refill
//   dc_rd_req/addr -> dc_rd_valid/data/done   D-cache refill
//   dc_wb_req/addr/wdata -> dc_wb_beat/done   D-cache writeback
//   mem_cmd_valid/we/addr <- mem_cmd_ready    burst command
//   mem_rvalid/rdata                          read beats from memory
//   mem_wready/mem_wdata                      write beats to memory
// Writeback has absolute priority; the two refill classes share a
// round-robin pointer.
// ---------------------------------------------------------------------------
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned READ_BURST_LEN  = 8,
  parameter int unsigned WRITE_BURST_LEN = 8
) (
  input  logic                               cpu_clk,
  input  logic                               cpu_rst,
  input  logic                               ic_rd_req,
  input  logic [ADDR_WIDTH-1:0]              ic_rd_addr,
  output logic                               ic_rd_valid,
  output logic [DATA_WIDTH-1:0]              ic_rd_data,
  output logic                               ic_rd_done,
  input  logic                               dc_rd_req,
  input  logic [ADDR_WIDTH-1:0]              dc_rd_addr,
  output logic                               dc_rd_valid,
  output logic [DATA_WIDTH-1:0]              dc_rd_data,
  output logic                               dc_rd_done,
  input  logic                               dc_wb_req,
  input  logic [ADDR_WIDTH-1:0]              dc_wb_addr,
  input  logic [DATA_WIDTH-1:0]              dc_wb_wdata,
  output logic [$clog2(WRITE_BURST_LEN)-1:0] dc_wb_beat,
  output logic                               dc_wb_done,
  output logic                               mem_cmd_valid,
  output logic                               mem_cmd_we,
  output logic [ADDR_WIDTH-1:0]              mem_cmd_addr,
  input  logic                               mem_cmd_ready,
  input  logic                               mem_rvalid,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  input  logic                               mem_wready,
  output logic [DATA_WIDTH-1:0]              mem_wdata
);

  localparam int unsigned RD_OFF = burst_off_bits(READ_BURST_LEN, DATA_WIDTH);
  localparam int unsigned WR_OFF = burst_off_bits(WRITE_BURST_LEN, DATA_WIDTH);
  localparam int unsigned RB_BW  = $clog2(READ_BURST_LEN);
  localparam int unsigned WB_BW  = $clog2(WRITE_BURST_LEN);
  localparam int unsigned CNT_W  = (RB_BW > WB_BW) ? RB_BW : WB_BW;

  localparam logic [ADDR_WIDTH-1:0] ONES    = '1;
  localparam logic [ADDR_WIDTH-1:0] RD_MASK = ONES << RD_OFF;
  localparam logic [ADDR_WIDTH-1:0] WR_MASK = ONES << WR_OFF;
  localparam logic [CNT_W-1:0]      RD_LAST = CNT_W'(READ_BURST_LEN - 1);
  localparam logic [CNT_W-1:0]      WR_LAST = CNT_W'(WRITE_BURST_LEN - 1);

  arb_state_e            r_state, w_next_state;
  owner_e                r_owner, w_next_owner;
  logic [ADDR_WIDTH-1:0] r_addr,  w_next_addr;
  logic [CNT_W-1:0]      r_cnt,   w_next_cnt;
  logic [1:0]            w_rr_gnt;
  logic                  w_rr_adv;

  mem_rr_arbiter u_rr (
    .i_clk     (cpu_clk),
    .i_rst     (cpu_rst),
    .i_req     ({ic_rd_req, dc_rd_req}),
    .i_advance (w_rr_adv),
    .o_gnt     (w_rr_gnt)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      r_addr  <= w_next_addr;
      r_cnt   <= w_next_cnt;
    end
  end

  // All outputs derive from r_state, so reset clears them asynchronously.
  always_comb begin
    w_next_state  = r_state;
    w_next_owner  = r_owner;
    w_next_addr   = r_addr;
    w_next_cnt    = r_cnt;
    w_rr_adv      = 1'b0;
    ic_rd_valid   = 1'b0;
    ic_rd_data    = '0;
    ic_rd_done    = 1'b0;
    dc_rd_valid   = 1'b0;
    dc_rd_data    = '0;
    dc_rd_done    = 1'b0;
    dc_wb_beat    = '0;
    dc_wb_done    = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_wdata     = '0;

    case (r_state)
      ST_IDLE: begin
        if (dc_wb_req) begin
          w_next_owner = OWN_DC_WB;
          w_next_addr  = dc_wb_addr & WR_MASK;
          w_next_state = ST_CMD;
        end else if (w_rr_gnt[RR_DC]) begin
          w_next_owner = OWN_DC_RD;
          w_next_addr  = dc_rd_addr & RD_MASK;
          w_rr_adv     = 1'b1;
          w_next_state = ST_CMD;
        end else if (w_rr_gnt[RR_IC]) begin
          w_next_owner = OWN_IC_RD;
          w_next_addr  = ic_rd_addr & RD_MASK;
          w_rr_adv     = 1'b1;
          w_next_state = ST_CMD;
        end
      end

      ST_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = (r_owner == OWN_DC_WB);
        mem_cmd_addr  = r_addr;
        if (mem_cmd_ready) begin
          w_next_cnt   = '0;
          w_next_state = (r_owner == OWN_DC_WB) ? ST_WR_BURST : ST_RD_BURST;
        end
      end

      ST_RD_BURST: begin
        if (mem_rvalid) begin
          if (r_owner == OWN_IC_RD) begin
            ic_rd_valid = 1'b1;
            ic_rd_data  = mem_rdata;
            ic_rd_done  = (r_cnt == RD_LAST);
          end else begin
            dc_rd_valid = 1'b1;
            dc_rd_data  = mem_rdata;
            dc_rd_done  = (r_cnt == RD_LAST);
          end
          w_next_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == RD_LAST) begin
            w_next_cnt   = '0;
            w_next_owner = OWN_NONE;
            w_next_state = ST_IDLE;
          end
        end
      end

      ST_WR_BURST: begin
        mem_wdata  = dc_wb_wdata;
        dc_wb_beat = r_cnt[WB_BW-1:0];
        if (mem_wready) begin
          dc_wb_done = (r_cnt == WR_LAST);
          w_next_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == WR_LAST) begin
            w_next_cnt   = '0;
            w_next_owner = OWN_NONE;
            w_next_state = ST_IDLE;
          end
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
`timescale 1ns/1ps
module tb_l1_mem_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        ic_rd_req, dc_rd_req, dc_wb_req;
  logic [31:0] ic_rd_addr, dc_rd_addr, dc_wb_addr, dc_wb_wdata;
  logic        ic_rd_valid, ic_rd_done, dc_rd_valid, dc_rd_done, dc_wb_done;
  logic [31:0] ic_rd_data, dc_rd_data;
  logic [2:0]  dc_wb_beat;
  logic        mem_cmd_valid, mem_cmd_we, mem_cmd_ready;
  logic [31:0] mem_cmd_addr;
  logic        mem_rvalid, mem_wready;
  logic [31:0] mem_rdata, mem_wdata;

  always #5 cpu_clk = ~cpu_clk;

  // Writeback line source: beat n of the dirty line holds 0xB0+n.
  assign dc_wb_wdata = 32'h0000_00B0 + 32'(dc_wb_beat);

  l1_mem_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .READ_BURST_LEN  (8),
    .WRITE_BURST_LEN (8)
  ) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .ic_rd_req     (ic_rd_req),
    .ic_rd_addr    (ic_rd_addr),
    .ic_rd_valid   (ic_rd_valid),
    .ic_rd_data    (ic_rd_data),
    .ic_rd_done    (ic_rd_done),
    .dc_rd_req     (dc_rd_req),
    .dc_rd_addr    (dc_rd_addr),
    .dc_rd_valid   (dc_rd_valid),
    .dc_rd_data    (dc_rd_data),
    .dc_rd_done    (dc_rd_done),
    .dc_wb_req     (dc_wb_req),
    .dc_wb_addr    (dc_wb_addr),
    .dc_wb_wdata   (dc_wb_wdata),
    .dc_wb_beat    (dc_wb_beat),
    .dc_wb_done    (dc_wb_done),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_we    (mem_cmd_we),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_wready    (mem_wready),
    .mem_wdata     (mem_wdata)
  );

  int checks   = 0;
  int failures = 0;
  logic [39:0] exp_q[$];
  logic        wb_phase = 1'b0;

  // Event encoding: {kind[3:0], beat[2:0], flag, value[31:0]}
  //   kind 1 = command handshake (flag=we, value=addr)
  //   kind 2 = I-cache beat, kind 3 = D-cache beat (flag=done, value=data)
  //   kind 4 = writeback beat (beat index, flag=done, value=mem_wdata)
  function automatic logic [39:0] ev(input logic [3:0] k, input logic [2:0] b,
                                     input logic d, input logic [31:0] v);
    return {k, b, d, v};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic observe(input string name, input logic [39:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected actual=%h required=none", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Monitor: every DUT strobe is popped against the scoreboard.
  always @(negedge cpu_clk) begin
    if (mem_cmd_valid && mem_cmd_ready)
      observe("cmd", ev(4'd1, 3'd0, mem_cmd_we, mem_cmd_addr));
    if (ic_rd_valid || ic_rd_done)
      observe("ic_beat", ev(4'd2, 3'd0, ic_rd_done, ic_rd_data));
    if (dc_rd_valid || dc_rd_done)
      observe("dc_beat", ev(4'd3, 3'd0, dc_rd_done, dc_rd_data));
    if ((wb_phase && mem_wready) || dc_wb_done)
      observe("wb_beat", ev(4'd4, dc_wb_beat, dc_wb_done, mem_wdata));
  end

  // Wait for the command to appear; returns 0 on timeout.
  task automatic wait_cmd(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge cpu_clk);
      seen = mem_cmd_valid;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL cmd_timeout actual=no_cmd required=cmd_valid");
    end
  endtask

  // Serve one granted burst. kind: 1 = ic read, 2 = dc read, 3 = writeback.
  // The caller has already raised the request; the task drops it after done.
  task automatic serve(input int kind, input logic [31:0] addr_exp,
                       input logic [31:0] base, input int ready_delay,
                       input bit wtoggle);
    bit seen;
    int n;
    int idx;
    exp_q.push_back(ev(4'd1, 3'd0, (kind == 3), addr_exp));
    mem_cmd_ready = (ready_delay == 0);
    wait_cmd(seen);
    if (!seen) return;
    if (ready_delay > 0) begin
      for (int d = 0; d < ready_delay; d++) begin
        if (d > 0) @(negedge cpu_clk);
        check("cmd_hold", 40'({mem_cmd_valid, mem_cmd_we, mem_cmd_addr}),
              40'({1'b1, (kind == 3), addr_exp}));
        @(posedge cpu_clk); #1;
      end
      mem_cmd_ready = 1'b1;
      @(negedge cpu_clk);
    end
    if (kind != 3) begin
      for (int i = 0; i < 8; i++) begin
        @(posedge cpu_clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = base + 32'(i);
        exp_q.push_back(ev((kind == 1) ? 4'd2 : 4'd3, 3'd0, (i == 7), base + 32'(i)));
      end
      @(posedge cpu_clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (kind == 1) ic_rd_req = 1'b0;
      else           dc_rd_req = 1'b0;
    end else begin
      wb_phase = 1'b1;
      n   = 0;
      idx = 0;
      while (n < 8 && idx < 40) begin
        @(posedge cpu_clk); #1;
        mem_wready = wtoggle ? ((idx % 2) == 0) : 1'b1;
        if (mem_wready) begin
          exp_q.push_back(ev(4'd4, n[2:0], (n == 7), 32'(32'h0000_00B0 + n)));
          n++;
        end else begin
          @(negedge cpu_clk);
          check("wb_beat_hold", 40'(dc_wb_beat), 40'(n[2:0]));
        end
        idx++;
      end
      @(posedge cpu_clk); #1;
      mem_wready = 1'b0;
      wb_phase   = 1'b0;
      dc_wb_req  = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    cpu_rst = 1'b1;
    ic_rd_req = 0; dc_rd_req = 0; dc_wb_req = 0;
    ic_rd_addr = 0; dc_rd_addr = 0; dc_wb_addr = 0;
    mem_cmd_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_wready = 0;
    repeat (2) @(posedge cpu_clk);
    #1;
    check("rst_strobes", 40'({ic_rd_valid, ic_rd_done, dc_rd_valid, dc_rd_done,
                              dc_wb_done, mem_cmd_valid, mem_cmd_we}), 40'd0);
    check("rst_cmd_addr", 40'(mem_cmd_addr), 40'd0);
    check("rst_rd_data", 40'({ic_rd_data, dc_rd_data}), 40'd0);
    check("rst_wdata_beat", 40'({mem_wdata, dc_wb_beat}), 40'd0);
    cpu_rst = 1'b0;

    // Single I-cache refill with unaligned address.
    @(posedge cpu_clk); #1;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h104;
    serve(1, 32'h100, 32'hA0, 0, 1'b0);

    // Simultaneous refills twice: dc, ic, dc, ic.
    @(posedge cpu_clk); #1;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1000;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h2008;
    serve(2, 32'h2000, 32'h10, 0, 1'b0);
    serve(1, 32'h1000, 32'h20, 0, 1'b0);
    @(posedge cpu_clk); #1;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h3010;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h4000;
    serve(2, 32'h4000, 32'h30, 0, 1'b0);
    serve(1, 32'h3000, 32'h40, 0, 1'b0);

    // Writeback and D-cache refill together; slow command accept, toggling wready.
    @(posedge cpu_clk); #1;
    dc_wb_req = 1'b1; dc_wb_addr = 32'h200;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h244;
    serve(3, 32'h200, 32'h0, 2, 1'b1);
    serve(2, 32'h240, 32'hC0, 0, 1'b0);

    // Stray read/write beats while idle must not reach any port.
    @(posedge cpu_clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD; mem_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      check("idle_rvalid", 40'({ic_rd_valid, dc_rd_valid, mem_cmd_valid, dc_wb_done}), 40'd0);
    end
    @(posedge cpu_clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_wready = 1'b0;

    // Reset during beat 3 of a D-cache refill.
    mem_cmd_ready = 1'b1;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h500;
    exp_q.push_back(ev(4'd1, 3'd0, 1'b0, 32'h500));
    wait_cmd(seen);
    for (int i = 0; i < 3; i++) begin
      @(posedge cpu_clk); #1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hE0 + 32'(i);
      exp_q.push_back(ev(4'd3, 3'd0, 1'b0, 32'hE0 + 32'(i)));
    end
    @(posedge cpu_clk); #1;
    mem_rdata = 32'hE3;
    #1 cpu_rst = 1'b1;
    #1;
    check("rst_async_dc", 40'({dc_rd_valid, dc_rd_done, dc_rd_data}), 40'd0);
    check("rst_async_cmd", 40'({mem_cmd_valid, ic_rd_valid, ic_rd_done}), 40'd0);
    mem_rvalid = 1'b0; mem_rdata = '0; dc_rd_req = 1'b0;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;

    // After reset: pointer back to dc, fresh burst counts all 8 beats.
    @(posedge cpu_clk); #1;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h700;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h61C;
    serve(2, 32'h600, 32'h60, 0, 1'b0);
    serve(1, 32'h700, 32'h70, 0, 1'b0);

    repeat (3) @(posedge cpu_clk);
    #1;
    check("queue_empty", 40'(exp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
